// File: rtl/uc_multiciclo_if.sv
// Bundle of control/status signals between microc's datapath and its multi-cycle
// control unit.
//   slave  : the control unit (consumes Opcode/z/run/step, drives strobes and status)
//   master : the datapath/CPU side (drives Opcode/z/run/step, consumes strobes)
interface uc_multiciclo_if #(
    parameter int unsigned CNT_W = 16
);
    logic [5:0]       Opcode;   // opcode field from instruction memory
    logic             z;        // zero-flag register output
    logic             run;      // execute continuously
    logic             step;     // one-cycle pulse: execute one instruction
    logic             s_inc;    // PC mux: 1 = PC+1, 0 = jump target
    logic             s_inm;    // regfile write-data mux: 1 = immediate
    logic             we3;      // regfile write enable
    logic             wez;      // zero-flag write enable
    logic [2:0]       Op;       // ALU operation
    logic             pc_we;    // PC write enable
    logic             halted;   // high while in HALT
    logic [CNT_W-1:0] retired;  // executed-instruction count

    modport slave (
        input  Opcode, z, run, step,
        output s_inc, s_inm, we3, wez, Op, pc_we, halted, retired
    );

    modport master (
        output Opcode, z, run, step,
        input  s_inc, s_inm, we3, wez, Op, pc_we, halted, retired
    );
endinterface

// File: rtl/uc_multiciclo.sv
// Multi-cycle control unit for microc. Sequences IDLE -> FETCH (FETCH_CYCLES cycles)
// -> EXEC (1 cycle), decodes the opcode into datapath strobes during EXEC, supports
// run / single-step operation, an absorbing HALT state and a retired-instruction counter.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low reset
//   bus   : uc_multiciclo_if slave modport (Opcode, z, run, step in;
//           s_inc, s_inm, we3, wez, Op, pc_we, halted, retired out)
module uc_multiciclo #(
    parameter int unsigned FETCH_CYCLES = 1,   // legal 1..4
    parameter int unsigned CNT_W        = 16
) (
    input  logic              clk,
    input  logic              reset,
    uc_multiciclo_if.slave    bus
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StFetch = 2'd1;
    localparam logic [1:0] StExec  = 2'd2;
    localparam logic [1:0] StHalt  = 2'd3;

    localparam logic [1:0] FetchLast = 2'(FETCH_CYCLES - 1);
    localparam logic [5:0] OpcHalt   = 6'b000011;

    logic [1:0]       state_q, state_d;
    logic [1:0]       fetch_cnt_q, fetch_cnt_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    logic             is_halt_op;

    assign is_halt_op = (bus.Opcode == OpcHalt);

    // Next-state, fetch counter and retired counter
    always_comb begin
        state_d     = state_q;
        fetch_cnt_d = fetch_cnt_q;
        retired_d   = retired_q;
        case (state_q)
            StIdle: begin
                fetch_cnt_d = 2'd0;
                // run and step both lead to FETCH; which one won only matters in EXEC
                if (bus.run || bus.step) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                if (fetch_cnt_q == FetchLast) begin
                    state_d     = StExec;
                    fetch_cnt_d = 2'd0;
                end else begin
                    fetch_cnt_d = fetch_cnt_q + 2'd1;
                end
            end
            StExec: begin
                fetch_cnt_d = 2'd0;
                if (is_halt_op) begin
                    state_d = StHalt;
                end else begin
                    retired_d = retired_q + 1'b1;  // wraps naturally
                    state_d   = bus.run ? StFetch : StIdle;
                end
            end
            default: begin
                state_d = StHalt;  // absorbing until reset
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            fetch_cnt_q <= 2'd0;
            retired_q   <= '0;
        end else begin
            state_q     <= state_d;
            fetch_cnt_q <= fetch_cnt_d;
            retired_q   <= retired_d;
        end
    end

    // Strobe decode: only active in EXEC; state is cleared asynchronously by reset,
    // so every strobe falls as soon as reset asserts.
    always_comb begin
        bus.s_inc = 1'b0;
        bus.s_inm = 1'b0;
        bus.we3   = 1'b0;
        bus.wez   = 1'b0;
        bus.Op    = 3'b000;
        bus.pc_we = 1'b0;
        if (state_q == StExec) begin
            bus.pc_we = 1'b1;
            if (bus.Opcode[5]) begin
                // R-type ALU
                bus.Op    = bus.Opcode[4:2];
                bus.we3   = 1'b1;
                bus.wez   = 1'b1;
                bus.s_inc = 1'b1;
            end else if (bus.Opcode[4]) begin
                // I-type ALU
                bus.Op    = bus.Opcode[3:1];
                bus.we3   = 1'b1;
                bus.wez   = 1'b1;
                bus.s_inm = 1'b1;
                bus.s_inc = 1'b1;
            end else if (bus.Opcode[3:2] == 2'b10) begin
                // LI
                bus.we3   = 1'b1;
                bus.s_inm = 1'b1;
                bus.s_inc = 1'b1;
            end else if (bus.Opcode[3:2] == 2'b00) begin
                case (bus.Opcode[1:0])
                    2'b00:   bus.s_inc = 1'b0;      // J
                    2'b01:   bus.s_inc = ~bus.z;    // JZ: taken when z=1
                    2'b10:   bus.s_inc = bus.z;     // JNZ: taken when z=0
                    default: bus.pc_we = 1'b0;      // HALT: PC frozen
                endcase
            end else begin
                // NOP (0001xx and anything unlisted)
                bus.s_inc = 1'b1;
            end
        end
    end

    assign bus.halted  = (state_q == StHalt);
    assign bus.retired = retired_q;

endmodule
